multiplier_by_powerof2: RTL and testbench
=========================================

# multiplier_by_powerof2

Streaming saturating multiply-by-power-of-two unit: the left-shift counterpart to the rounding divide-by-power-of-two used in requantization. It accepts a signed 32-bit operand and an exponent over a valid/ready handshake. It returns `operand * 2^exponent`, clamped to the int32 range, through a two-stage pipeline with full backpressure. It sits on the requantization path wherever a positive shift (left shift) is applied before the fixed-point multiply, and counts saturation events for debug.

## Interface
- `DATA_W`, 32: operand/result width. Only 32 is supported.
- `EXP_W`, 6: exponent width.
- `CNT_W`, 16: saturation event counter width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: operand/exponent valid.
- `in_ready` output 1: unit accepts input this cycle.
- `multiplicand` input DATA_W: signed two's-complement operand.
- `exponent` input EXP_W: unsigned shift amount; meaningful range 0..31, values 32..63 are legal.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts result.
- `product` output DATA_W: saturated signed result.
- `saturated` output 1: this result was clamped; qualified by `out_valid`.
- `sat_count` output CNT_W: number of clamped results delivered, sticky at all-ones.
- `sat_clr` input 1: synchronous clear of `sat_count`.

## Operation
- Result is the exact value `multiplicand * 2^exponent` when it fits in int32.
- Otherwise the result is 0x7FFFFFFF if `multiplicand` > 0, or 0x80000000 if `multiplicand` < 0, and `saturated`=1.
- Overflow test for exponent e in 1..31: bits [31:31-e] of `multiplicand` are not all equal. For e=0, no overflow is possible.
- e ≥ 32: `multiplicand`=0 gives 0 with `saturated`=0; any nonzero value saturates.
- `multiplicand`=0 never saturates.
- Stage 1 (S1) registers the operand and exponent, plus the precomputed overflow flag and sign.
- Stage 2 (S2) registers the shifted value and the saturation mux output; `product` and `saturated` are driven from S2 registers.
- `sat_count` increments on each output handshake (`out_valid && out_ready`) with `saturated`=1, and holds at 2^CNT_W−1.
- `sat_clr` has priority over the hold value. When `sat_clr` and a counted handshake occur in the same cycle, `sat_count` becomes 1.

## Timing
- Reset values: `out_valid`=0, `product`=0, `saturated`=0, `sat_count`=0, all stage valids=0. `in_ready`=1 after reset deasserts.
- Input accepted on `in_valid && in_ready`.
- Result appears with `out_valid`=1 exactly 2 cycles after acceptance, provided there is no stall.
- Throughput is 1 result/cycle while `out_ready`=1.
- S2 advances when `!s2_valid || out_ready`.
- S1 advances when `!s1_valid || s2_advance`.
- `in_ready` = `!s1_valid || s2_advance`, which is combinational from `out_ready`.
- While stalled (`out_valid && !out_ready`), `product`, `saturated` and `out_valid` hold stable. No data is dropped or duplicated.
- With both stages full and stalled, `in_ready`=0. The first cycle `out_ready`=1 drains S2, moves S1 to S2, and accepts a new input in the same cycle.
- Asserting `rst` mid-stream discards both stages immediately: `out_valid` drops asynchronously and in-flight data is lost.

## Structure
- Shared package `nnacc_pkg` holds:
  - `DATA_W` and `EXP_W` constants.
  - `INT32_MAX` = 32'h7FFF_FFFF and `INT32_MIN` = 32'h8000_0000.
  - A result struct {product, saturated}.
- One combinational sub-module, `sat_lshift_core`: inputs operand and exponent; outputs shifted value, overflow and sign. It is reused wherever a saturating positive shift is needed.
- The top level owns the handshake, the two stage registers and the counter.

## Test plan
- Basic: 0x0000_0003, e=4 → `product`=0x0000_0030, `saturated`=0, `out_valid` 2 cycles after acceptance.
- Saturation boundaries:
  - 0x4000_0000, e=1 → 0x7FFF_FFFF, `saturated`=1.
  - 0xC000_0000, e=1 → 0x8000_0000, `saturated`=0 (exact).
  - 0x8000_0000, e=1 → 0x8000_0000, `saturated`=1.
- Exponent extremes:
  - 0xFFFF_FFFF, e=31 → 0x8000_0000, `saturated`=0.
  - 0x0000_0001, e=40 → 0x7FFF_FFFF, `saturated`=1.
  - 0, e=63 → 0, `saturated`=0.
  - 0x1234_5678, e=0 → 0x1234_5678.
- Backpressure: stream 8 back-to-back operands with `out_ready` toggling randomly → outputs in order, none lost or repeated, outputs stable while stalled, `in_ready`=0 only when both stages are full and stalled.
- Counter:
  - 3 saturating handshakes → `sat_count`=3.
  - `sat_clr` concurrent with a saturating handshake → 1.
  - Force 65540 saturating results → `sat_count` holds at 0xFFFF.
- Reset mid-stream: assert `rst` with both stages valid → `out_valid`=0 and `sat_count`=0 immediately; after release the first new input yields a correct result 2 cycles later.

Source files
------------

// File: rtl/nnacc_pkg.sv
// Shared types and constants for the requantization datapath.
// Holds operand/exponent widths, int32 clamp limits, the result struct
// and a helper that picks the clamp value from the operand sign.
package nnacc_pkg;

  localparam int DATA_W = 32;
  localparam int EXP_W  = 6;
  localparam int CNT_W  = 16;

  localparam logic [DATA_W-1:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] INT32_MIN = 32'h8000_0000;

  typedef struct packed {
    logic [DATA_W-1:0] product;
    logic              saturated;
  } result_t;

  // Clamp value for an overflowing result, chosen by the operand sign.
  function automatic logic [DATA_W-1:0] sat_value(input logic neg);
    return neg ? INT32_MIN : INT32_MAX;
  endfunction

endpackage

// File: rtl/multiplier_by_powerof2_if.sv
// Handshake bundle for the saturating multiply-by-power-of-two unit.
// Ports: input side (in_valid/in_ready/multiplicand/exponent), output side
// (out_valid/out_ready/product/saturated), debug counter (sat_count/sat_clr).
interface multiplier_by_powerof2_if;
  import nnacc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] multiplicand;
  logic [EXP_W-1:0]  exponent;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] product;
  logic              saturated;
  logic [CNT_W-1:0]  sat_count;
  logic              sat_clr;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, multiplicand, exponent, out_ready, sat_clr,
    input  in_ready, out_valid, product, saturated, sat_count
  );

  // Unit side.
  modport slave (
    input  in_valid, multiplicand, exponent, out_ready, sat_clr,
    output in_ready, out_valid, product, saturated, sat_count
  );

endinterface

// File: rtl/sat_lshift_core.sv
// Combinational saturating left-shift helper.
// Ports: operand/exponent in; shifted value (low 32 bits of operand << e),
// overflow (result does not fit int32) and operand sign out.
module sat_lshift_core
  import nnacc_pkg::*;
(
  input  logic [DATA_W-1:0] operand,
  input  logic [EXP_W-1:0]  exponent,
  output logic [DATA_W-1:0] shifted,
  output logic              overflow,
  output logic              sign
);

  logic [4:0]        sh_amt;
  logic [DATA_W-1:0] top_bits;

  assign sh_amt  = exponent[4:0];
  assign shifted = operand << sh_amt;
  assign sign    = operand[DATA_W-1];

  // An arithmetic right shift by (31-e) leaves exactly bits [31:31-e] in
  // the low positions, sign-extended; they are all equal iff the result is
  // all zeros or all ones. For e=0 this is just the sign bit, never overflow.
  assign top_bits = $signed(operand) >>> (5'd31 - sh_amt);

  always_comb begin
    overflow = 1'b0;
    if (exponent[EXP_W-1:5] != '0) begin
      // Shift of 32 or more: only zero survives.
      overflow = (operand != '0);
    end else begin
      overflow = !((top_bits == '0) || (top_bits == '1));
    end
  end

endmodule

// File: rtl/multiplier_by_powerof2.sv
// Streaming int32 * 2^e with clamping, two-stage pipeline, valid/ready.
// Ports: clk, rst (async, active-high), bus (slave side of the handshake
// bundle). Result 2 cycles after acceptance; in_ready drops only when both
// stages are full and the output is stalled.
module multiplier_by_powerof2
  import nnacc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  multiplier_by_powerof2_if.slave bus
);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_operand_q, s1_operand_d;
  logic [EXP_W-1:0]  s1_exponent_q, s1_exponent_d;
  logic              s1_ovf_q, s1_ovf_d;
  logic              s1_sign_q, s1_sign_d;
  logic              s2_valid_q, s2_valid_d;
  result_t           s2_res_q, s2_res_d;
  logic [CNT_W-1:0]  sat_count_q, sat_count_d;

  logic              s1_advance, s2_advance, sat_hs;
  logic              pre_ovf, pre_sign;
  logic [DATA_W-1:0] pre_shifted_unused;
  logic [DATA_W-1:0] s1_shifted;
  logic              s1_ovf_unused, s1_sign_unused;

  // Overflow and sign are resolved on the raw input so S2 only has a mux.
  sat_lshift_core u_pre (
    .operand  (bus.multiplicand),
    .exponent (bus.exponent),
    .shifted  (pre_shifted_unused),
    .overflow (pre_ovf),
    .sign     (pre_sign)
  );

  // The shift itself is done from the S1 registers.
  sat_lshift_core u_s1 (
    .operand  (s1_operand_q),
    .exponent (s1_exponent_q),
    .shifted  (s1_shifted),
    .overflow (s1_ovf_unused),
    .sign     (s1_sign_unused)
  );

  assign s2_advance = !s2_valid_q || bus.out_ready;
  assign s1_advance = !s1_valid_q || s2_advance;
  assign sat_hs     = s2_valid_q && bus.out_ready && s2_res_q.saturated;

  assign bus.in_ready  = s1_advance;
  assign bus.out_valid = s2_valid_q;
  assign bus.product   = s2_res_q.product;
  assign bus.saturated = s2_res_q.saturated;
  assign bus.sat_count = sat_count_q;

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_operand_d  = s1_operand_q;
    s1_exponent_d = s1_exponent_q;
    s1_ovf_d      = s1_ovf_q;
    s1_sign_d     = s1_sign_q;
    s2_valid_d    = s2_valid_q;
    s2_res_d      = s2_res_q;
    sat_count_d   = sat_count_q;

    if (s1_advance) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_operand_d  = bus.multiplicand;
        s1_exponent_d = bus.exponent;
        s1_ovf_d      = pre_ovf;
        s1_sign_d     = pre_sign;
      end
    end

    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d.product   = s1_ovf_q ? sat_value(s1_sign_q) : s1_shifted;
        s2_res_d.saturated = s1_ovf_q;
      end
    end

    // Clear wins over hold; a clear coinciding with a counted event
    // leaves that event counted.
    if (bus.sat_clr) begin
      sat_count_d = sat_hs ? CNT_W'(1) : '0;
    end else if (sat_hs && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_operand_q  <= '0;
      s1_exponent_q <= '0;
      s1_ovf_q      <= 1'b0;
      s1_sign_q     <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_res_q      <= '0;
      sat_count_q   <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_operand_q  <= s1_operand_d;
      s1_exponent_q <= s1_exponent_d;
      s1_ovf_q      <= s1_ovf_d;
      s1_sign_q     <= s1_sign_d;
      s2_valid_q    <= s2_valid_d;
      s2_res_q      <= s2_res_d;
      sat_count_q   <= sat_count_d;
    end
  end

endmodule

// File: tb/tb_multiplier_by_powerof2.sv
// Self-checking bench for multiplier_by_powerof2.
// Reference model uses 64-bit arithmetic and an in-order expected queue.
// Each cycle inputs are driven at the falling edge and outputs sampled 1 ns later.
module tb_multiplier_by_powerof2;
  import nnacc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multiplier_by_powerof2_if bus();

  multiplier_by_powerof2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  result_t     exp_q[$];
  logic [15:0] model_cnt = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_prod;
  logic        prev_sat;

  function automatic result_t ref_mul(input logic [31:0] op, input logic [5:0] e);
    result_t r;
    longint  v;
    longint  p;
    v = longint'($signed(op));
    r.saturated = 1'b0;
    r.product   = op;
    if (v == 0) begin
      r.product = '0;
      return r;
    end
    if (e >= 6'd32) begin
      r.saturated = 1'b1;
    end else begin
      p = v * (longint'(1) << e);
      if (p > 64'sd2147483647 || p < -64'sd2147483648) r.saturated = 1'b1;
      else r.product = p[31:0];
    end
    if (r.saturated) r.product = (v > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // One clock cycle: drive, sample/score, then advance to the next falling edge.
  task automatic cycle(input logic iv, input logic [31:0] op, input logic [5:0] e,
                       input logic ordy, input logic clr, output logic acc);
    result_t ex;
    logic    hs_sat;
    bus.in_valid     = iv;
    bus.multiplicand = op;
    bus.exponent     = e;
    bus.out_ready    = ordy;
    bus.sat_clr      = clr;
    #1;
    chk("sat_count", bus.sat_count, model_cnt);
    if (prev_stall) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_product", bus.product, prev_prod);
      chk("stall_saturated", bus.saturated, prev_sat);
    end
    chk("in_ready", bus.in_ready, !(exp_q.size() == 2 && !ordy));
    if (exp_q.size() == 0) chk("out_valid_empty", bus.out_valid, 0);
    if (exp_q.size() == 2) chk("out_valid_full", bus.out_valid, 1);
    hs_sat = 1'b0;
    if (bus.out_valid === 1'b1 && ordy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", bus.out_valid, 0);
      end else begin
        ex = exp_q.pop_front();
        chk("product", bus.product, ex.product);
        chk("saturated", bus.saturated, ex.saturated);
        hs_sat = ex.saturated;
      end
    end
    if (clr) model_cnt = hs_sat ? 16'd1 : 16'd0;
    else if (hs_sat && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    acc = iv && (bus.in_ready === 1'b1);
    if (acc) exp_q.push_back(ref_mul(op, e));
    prev_stall = (bus.out_valid === 1'b1) && !ordy;
    prev_prod  = bus.product;
    prev_sat   = bus.saturated;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
  endtask

  task automatic lat_test(input string tag);
    logic acc;
    cycle(1'b1, 32'h0000_0003, 6'd4, 1'b1, 1'b0, acc);
    chk({tag, "_accept"}, acc, 1);
    chk({tag, "_lat1_valid"}, bus.out_valid, 0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk({tag, "_lat2_valid"}, bus.out_valid, 1);
    chk({tag, "_lat2_product"}, bus.product, 32'h0000_0030);
    chk({tag, "_lat2_saturated"}, bus.saturated, 0);
    idle(2);
  endtask

  logic [31:0] dir_op [8] = '{32'h4000_0000, 32'hC000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'h0000_0001, 32'h0000_0000, 32'h1234_5678, 32'h7FFF_FFFF};
  logic [5:0]  dir_e  [8] = '{6'd1, 6'd1, 6'd1, 6'd31, 6'd40, 6'd63, 6'd0, 6'd0};

  initial begin
    logic        acc;
    logic [31:0] ops [8];
    logic [5:0]  exps[8];
    int          idx;
    int          n;

    // Reset values
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.multiplicand = '0; bus.exponent = '0;
    bus.out_ready = 1'b0; bus.sat_clr = 1'b0;
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_product", bus.product, 0);
    chk("rst_saturated", bus.saturated, 0);
    chk("rst_sat_count", bus.sat_count, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // Basic latency
    lat_test("basic");

    // Boundary vectors, back to back
    for (int i = 0; i < 8; i++) cycle(1'b1, dir_op[i], dir_e[i], 1'b1, 1'b0, acc);
    idle(3);

    // Random vectors, full throughput
    for (int i = 0; i < 40; i++)
      cycle(1'b1, $urandom() >> $urandom_range(0, 31), 6'($urandom_range(0, 40)), 1'b1, 1'b0, acc);
    idle(3);

    // Backpressure: 8 operands with random out_ready
    for (int k = 0; k < 8; k++) begin
      ops[k] = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ops[k] = -ops[k];
      exps[k] = 6'($urandom_range(0, 40));
    end
    idx = 0;
    for (int c = 0; c < 400 && (idx < 8 || exp_q.size() != 0); c++) begin
      cycle(idx < 8, (idx < 8) ? ops[idx[2:0]] : 32'h0, (idx < 8) ? exps[idx[2:0]] : 6'h0,
            1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_sent", idx, 8);
    chk("bp_drained", exp_q.size(), 0);
    idle(1);

    // Counter: clear then three saturating handshakes
    cycle(1'b0, '0, '0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h4000_0000, 6'd1, 1'b1, 1'b0, acc);
    idle(3);
    chk("cnt_three", bus.sat_count, 3);

    // Clear concurrent with a saturating handshake
    cycle(1'b1, 32'h0000_0001, 6'd40, 1'b0, 1'b0, acc);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 5) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
      n++;
    end
    chk("clr_hs_wait_valid", bus.out_valid, 1);
    cycle(1'b0, '0, '0, 1'b1, 1'b1, acc);
    chk("cnt_clr_with_hs", bus.sat_count, 1);

    // Counter saturates and sticks
    for (int i = 0; i < 65540; i++) cycle(1'b1, 32'h0000_0001, 6'd40, 1'b1, 1'b0, acc);
    idle(3);
    chk("cnt_sticky", bus.sat_count, 16'hFFFF);

    // Reset with both stages full
    cycle(1'b1, 32'h0000_0005, 6'd2, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h0000_0007, 6'd3, 1'b0, 1'b0, acc);
    chk("mid_full_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_sat_count", bus.sat_count, 0);
    chk("mid_rst_product", bus.product, 0);
    exp_q.delete();
    model_cnt  = '0;
    prev_stall = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    lat_test("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
